// File: rtl/alu_pkg.sv
// Shared encodings for the iterative ALU: funct3/funct7 constants and the control state type.
package alu_pkg;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] M3_MUL    = 3'b000;
    localparam logic [2:0] M3_MULH   = 3'b001;
    localparam logic [2:0] M3_MULHSU = 3'b010;
    localparam logic [2:0] M3_MULHU  = 3'b011;
    localparam logic [2:0] M3_DIV    = 3'b100;
    localparam logic [2:0] M3_DIVU   = 3'b101;
    localparam logic [2:0] M3_REM    = 3'b110;
    localparam logic [2:0] M3_REMU   = 3'b111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 shift-add multiplier and restoring divider sharing one accumulator pair.
// Signed ops run on magnitudes; the sign is restored on the final result.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done_c,
    output logic [XLEN-1:0] result_c
);

    localparam int unsigned CW = $clog2(XLEN);

    logic              active;
    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   acc;
    logic [XLEN-1:0]   lo;
    logic [XLEN-1:0]   opb;
    logic [XLEN-1:0]   dvd;
    logic [2:0]        f3;
    logic              neg_res;
    logic              div0;

    logic              sgn_a_c;
    logic              sgn_b_c;
    logic              a_neg_c;
    logic              b_neg_c;
    logic [XLEN-1:0]   a_mag_c;
    logic [XLEN-1:0]   b_mag_c;

    logic [XLEN:0]     sum_c;
    logic [XLEN:0]     sh_c;
    logic [XLEN:0]     diff_c;
    logic [XLEN-1:0]   acc_n_c;
    logic [XLEN-1:0]   lo_n_c;
    logic [2*XLEN-1:0] prod_raw_c;
    logic [2*XLEN-1:0] prod_c;
    logic [XLEN-1:0]   quo_c;
    logic [XLEN-1:0]   rem_c;

    // Operand signedness and magnitudes at start
    always_comb begin
        sgn_a_c = (func3 == M3_MULH) || (func3 == M3_MULHSU) ||
                  (func3 == M3_DIV)  || (func3 == M3_REM);
        sgn_b_c = (func3 == M3_MULH) || (func3 == M3_DIV) || (func3 == M3_REM);
        a_neg_c = sgn_a_c && a[XLEN-1];
        b_neg_c = sgn_b_c && b[XLEN-1];
        a_mag_c = a_neg_c ? -a : a;
        b_mag_c = b_neg_c ? -b : b;
    end

    // One multiply or divide step per cycle
    always_comb begin
        sum_c  = {1'b0, acc} + (lo[0] ? {1'b0, opb} : '0);
        sh_c   = {acc, lo[XLEN-1]};
        diff_c = sh_c - {1'b0, opb};
        if (f3[2]) begin
            if (!diff_c[XLEN]) begin
                acc_n_c = diff_c[XLEN-1:0];
                lo_n_c  = {lo[XLEN-2:0], 1'b1};
            end else begin
                acc_n_c = sh_c[XLEN-1:0];
                lo_n_c  = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_n_c = sum_c[XLEN:1];
            lo_n_c  = {sum_c[0], lo[XLEN-1:1]};
        end
    end

    // Final result is taken from the values the last step produces
    always_comb begin
        prod_raw_c = {acc_n_c, lo_n_c};
        prod_c     = neg_res ? -prod_raw_c : prod_raw_c;
        quo_c      = neg_res ? -lo_n_c : lo_n_c;
        rem_c      = neg_res ? -acc_n_c : acc_n_c;
        done_c     = active && (cnt == CW'(XLEN - 1));
        result_c   = '0;
        case (f3)
            M3_MUL:                        result_c = prod_c[XLEN-1:0];
            M3_MULH, M3_MULHSU, M3_MULHU:  result_c = prod_c[2*XLEN-1:XLEN];
            M3_DIV, M3_DIVU:               result_c = div0 ? '1 : quo_c;
            default:                       result_c = div0 ? dvd : rem_c;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active  <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            lo      <= '0;
            opb     <= '0;
            dvd     <= '0;
            f3      <= '0;
            neg_res <= 1'b0;
            div0    <= 1'b0;
        end else if (start) begin
            active  <= 1'b1;
            cnt     <= '0;
            acc     <= '0;
            lo      <= a_mag_c;
            opb     <= b_mag_c;
            dvd     <= a;
            f3      <= func3;
            neg_res <= (func3[2] && func3[1]) ? a_neg_c : (a_neg_c ^ b_neg_c);
            div0    <= (b == '0);
        end else if (active) begin
            acc <= acc_n_c;
            lo  <= lo_n_c;
            cnt <= cnt + CW'(1);
            if (done_c) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/iter_alu.sv
// RV integer ALU: single-cycle base ops, iterative M-extension ops, valid/ready on both sides.
module iter_alu
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned EN_M = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] ra_d,
    input  logic [XLEN-1:0] rb_d,
    input  logic [2:0]      func3,
    input  logic [6:0]      func7,
    input  logic            imm_t,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rd_d,
    output logic            busy
);

    localparam int unsigned SHW = $clog2(XLEN);

    alu_state_e      state;
    alu_state_e      state_next;
    logic            accept_c;
    logic            is_m_c;
    logic            legal_c;
    logic [6:0]      f7_sh_c;
    logic [SHW-1:0]  shamt_c;
    logic [XLEN-1:0] base_c;
    logic            md_done_c;
    logic [XLEN-1:0] md_res_c;

    assign accept_c = in_valid && in_ready;

    // Encoding legality; on RV64 func7[0] is the top shift-amount bit
    always_comb begin
        f7_sh_c = (XLEN == 64) ? (func7 & 7'b1111110) : func7;
        is_m_c  = (EN_M != 0) && !imm_t && (func7 == F7_MULDIV);
        legal_c = 1'b0;
        if (imm_t) begin
            case (func3)
                F3_SLL:  legal_c = (f7_sh_c == F7_BASE);
                F3_SR:   legal_c = (f7_sh_c == F7_BASE) || (f7_sh_c == F7_ALT);
                default: legal_c = 1'b1;
            endcase
        end else if (func7 == F7_BASE) begin
            legal_c = 1'b1;
        end else if (func7 == F7_ALT) begin
            legal_c = (func3 == F3_ADD) || (func3 == F3_SR);
        end
    end

    // Single-cycle base operations
    always_comb begin
        shamt_c = rb_d[SHW-1:0];
        base_c  = '0;
        case (func3)
            F3_ADD:  base_c = (!imm_t && func7[5]) ? (ra_d - rb_d) : (ra_d + rb_d);
            F3_SLL:  base_c = ra_d << shamt_c;
            F3_SLT:  base_c = XLEN'($signed(ra_d) < $signed(rb_d));
            F3_SLTU: base_c = XLEN'(ra_d < rb_d);
            F3_XOR:  base_c = ra_d ^ rb_d;
            F3_SR:   base_c = func7[5] ? XLEN'($signed(ra_d) >>> shamt_c) : (ra_d >> shamt_c);
            F3_OR:   base_c = ra_d | rb_d;
            default: base_c = ra_d & rb_d;
        endcase
    end

    muldiv_iter #(
        .XLEN (XLEN)
    ) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .start    (accept_c && is_m_c),
        .func3    (func3),
        .a        (ra_d),
        .b        (rb_d),
        .done_c   (md_done_c),
        .result_c (md_res_c)
    );

    // State register; status outputs are registered decodes of the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next == ST_IDLE);
            busy      <= (state_next == ST_CALC);
            out_valid <= (state_next == ST_DONE);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    state_next = is_m_c ? ST_CALC : ST_DONE;
                end
            end
            ST_CALC: begin
                if (md_done_c) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Result register: loaded on a base-op accept or on the last iteration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_d <= '0;
        end else if (accept_c && !is_m_c) begin
            rd_d <= legal_c ? base_c : '0;
        end else if ((state == ST_CALC) && md_done_c) begin
            rd_d <= md_res_c;
        end
    end

endmodule

// File: tb/tb_iter_alu.sv
// Directed bench for iter_alu (XLEN=32): arithmetic reference model plus per-cycle output checker.
module tb_iter_alu;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ra_d;
    logic [31:0] rb_d;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic        imm_t;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] rd_d;
    logic        busy;

    iter_alu #(.XLEN(32), .EN_M(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ra_d      (ra_d),
        .rb_d      (rb_d),
        .func3     (func3),
        .func7     (func7),
        .imm_t     (imm_t),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rd_d      (rd_d),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        it;
        logic [31:0] a;
        logic [31:0] b;
        int          hold;
    } vec_t;

    vec_t        vq[$];
    int          n_vec = 0;
    int          n_err = 0;
    bit          pending = 1'b0;
    int          txn_id = 0;
    logic [31:0] exp_res = '0;
    int          exp_lat = 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: RISC-V semantics from 64-bit native arithmetic
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [6:0] f7,
                                          input logic it, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint          sp;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned up;
        int              sh;
        bit              legal;
        bit              ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        sh  = int'(b[4:0]);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (!it && f7 == 7'h01) begin
            case (f3)
                3'd0: begin up = ua * ub; return up[31:0]; end
                3'd1: begin sp = sa * sb; return sp[63:32]; end
                3'd2: begin sp = sa * longint'(ub); return sp[63:32]; end
                3'd3: begin up = ua * ub; return up[63:32]; end
                3'd4: begin
                    if (b == 0) return 32'hFFFF_FFFF;
                    if (ovf) return 32'h8000_0000;
                    sp = sa / sb; return sp[31:0];
                end
                3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
                3'd6: begin
                    if (b == 0) return a;
                    if (ovf) return 32'h0;
                    sp = sa % sb; return sp[31:0];
                end
                default: return (b == 0) ? a : a % b;
            endcase
        end
        if (it) legal = (f3 == 3'd1) ? (f7 == 7'h00) :
                        (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
        else    legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        if (!legal) return 32'h0;
        case (f3)
            3'd0: return (!it && f7 == 7'h20) ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return (sa < sb) ? 32'd1 : 32'd0;
            3'd3: return (ua < ub) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: begin sp = sa >>> sh; return (f7 == 7'h20) ? sp[31:0] : a >> sh; end
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic int lat_of(input logic [6:0] f7, input logic it);
        return (!it && f7 == 7'h01) ? 33 : 1;
    endfunction

    task automatic add(input logic [2:0] f3, input logic [6:0] f7, input logic it,
                       input logic [31:0] a, input logic [31:0] b, input int hold);
        vec_t v;
        v.f3 = f3; v.f7 = f7; v.it = it; v.a = a; v.b = b; v.hold = hold;
        vq.push_back(v);
    endtask

    task automatic scramble();
        ra_d  = $urandom;
        rb_d  = $urandom;
        func3 = 3'($urandom);
        func7 = 7'($urandom);
        imm_t = 1'($urandom);
    endtask

    task automatic start_op(input vec_t v);
        func3    = v.f3;
        func7    = v.f7;
        imm_t    = v.it;
        ra_d     = v.a;
        rb_d     = v.b;
        in_valid = 1'b1;
        exp_res  = model(v.f3, v.f7, v.it, v.a, v.b);
        exp_lat  = lat_of(v.f7, v.it);
        txn_id++;
        pending  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble();
    endtask

    // Issue one op, wait for completion, hold off the consumer, then retire it
    task automatic issue(input vec_t v);
        int n;
        start_op(v);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_seen", out_valid, 1);
        repeat (v.hold) begin
            in_valid = 1'b1;
            scramble();
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        pending   = 1'b0;
    endtask

    // Per-cycle checker, sampled on the falling edge
    initial begin
        int seen_id;
        int age;
        seen_id = 0;
        age     = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_rd_d", rd_d, 0);
                chk("rst_out_valid", out_valid, 0);
                chk("rst_busy", busy, 0);
            end else if (pending) begin
                if (txn_id != seen_id) begin
                    seen_id = txn_id;
                    age     = 0;
                end
                if (age == 0) begin
                    chk("pre_accept_in_ready", in_ready, 1);
                end else if (age < exp_lat) begin
                    chk("calc_out_valid", out_valid, 0);
                    chk("calc_busy", busy, (exp_lat > 1) ? 1 : 0);
                    chk("calc_in_ready", in_ready, 0);
                end else begin
                    chk("done_out_valid", out_valid, 1);
                    chk("done_rd_d", rd_d, exp_res);
                    chk("done_in_ready", in_ready, 0);
                    chk("done_busy", busy, 0);
                end
                age++;
            end else begin
                chk("idle_in_ready", in_ready, 1);
                chk("idle_out_valid", out_valid, 0);
                chk("idle_busy", busy, 0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        scramble();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Pin the reference model against hand-computed values
        chk("model_add_ovf", model(3'd0, 7'h00, 1'b0, 32'h7FFF_FFFF, 32'h1), 32'h8000_0000);
        chk("model_srai",    model(3'd5, 7'h20, 1'b1, 32'h8000_0000, 32'h4), 32'hF800_0000);
        chk("model_srli",    model(3'd5, 7'h00, 1'b1, 32'h8000_0000, 32'h4), 32'h0800_0000);
        chk("model_mulh",    model(3'd1, 7'h01, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'h0);
        chk("model_mulhu",   model(3'd3, 7'h01, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
        chk("model_div_ovf", model(3'd4, 7'h01, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
        chk("model_rem_z",   model(3'd6, 7'h01, 1'b0, 32'd7, 32'd0), 32'd7);
        chk("model_divu_z",  model(3'd5, 7'h01, 1'b0, 32'd5, 32'd0), 32'hFFFF_FFFF);
        chk("model_div_neg", model(3'd4, 7'h01, 1'b0, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        chk("model_rem_neg", model(3'd6, 7'h01, 1'b0, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

        // Stray out_ready while idle must do nothing
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;

        add(3'd0, 7'h00, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 0);
        add(3'd0, 7'h20, 1'b0, 32'd5,         32'd7,         0);
        add(3'd1, 7'h00, 1'b0, 32'h1,         32'h24,        0);
        add(3'd2, 7'h00, 1'b0, 32'hFFFF_FFFF, 32'h1,         0);
        add(3'd3, 7'h00, 1'b0, 32'hFFFF_FFFF, 32'h1,         0);
        add(3'd4, 7'h00, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
        add(3'd5, 7'h00, 1'b0, 32'h8000_0000, 32'h1F,        0);
        add(3'd5, 7'h20, 1'b0, 32'h8000_0000, 32'h1F,        0);
        add(3'd6, 7'h00, 1'b0, 32'h1234_0000, 32'h0000_5678, 0);
        add(3'd7, 7'h00, 1'b0, 32'hFFFF_0F0F, 32'h0F0F_FFFF, 10);
        add(3'd0, 7'h7F, 1'b1, 32'h10,        32'hFFFF_FFF0, 0);
        add(3'd5, 7'h20, 1'b1, 32'h8000_0000, 32'h4,         0);
        add(3'd5, 7'h00, 1'b1, 32'h8000_0000, 32'h4,         0);
        add(3'd1, 7'h01, 1'b1, 32'h1,         32'h1,         0);
        add(3'd4, 7'h20, 1'b0, 32'hFFFF_FFFF, 32'h1,         0);
        add(3'd0, 7'h01, 1'b0, 32'hFFFF_FFFD, 32'd7,         0);
        add(3'd1, 7'h01, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        add(3'd3, 7'h01, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        add(3'd2, 7'h01, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        add(3'd3, 7'h01, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 10);
        add(3'd4, 7'h01, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        add(3'd6, 7'h01, 1'b0, 32'd7,         32'd0,         0);
        add(3'd5, 7'h01, 1'b0, 32'd5,         32'd0,         0);
        add(3'd4, 7'h01, 1'b0, 32'hFFFF_FFF9, 32'd2,         0);
        add(3'd6, 7'h01, 1'b0, 32'hFFFF_FFF9, 32'd2,         0);
        add(3'd6, 7'h01, 1'b0, 32'd7,         32'hFFFF_FFFE, 0);
        add(3'd5, 7'h01, 1'b0, 32'hFFFF_FFFF, 32'h10,        0);
        add(3'd7, 7'h01, 1'b0, 32'd100,       32'd7,         0);
        add(3'd4, 7'h01, 1'b0, 32'd5,         32'd0,         0);
        add(3'd6, 7'h01, 1'b0, 32'hFFFF_FFFB, 32'd0,         0);
        add(3'd6, 7'h01, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);

        foreach (vq[i]) issue(vq[i]);

        // Reset in the middle of a DIVU: the operation must vanish
        v.f3 = 3'd5; v.f7 = 7'h01; v.it = 1'b0; v.a = 32'd1000; v.b = 32'd3; v.hold = 0;
        start_op(v);
        repeat (10) @(posedge clk);
        #1;
        rst     = 1'b1;
        pending = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;

        v.f3 = 3'd0; v.f7 = 7'h00; v.it = 1'b0; v.a = 32'd40; v.b = 32'd2; v.hold = 0;
        issue(v);
        repeat (3) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
